// File: rtl/snake_body_reader.sv
// snake_body_reader: streams entries 0..len-1 of the snake body bank over a
// valid/ready handshake after a start strobe, one beat per cycle.
// Optional collision compare against a captured query coordinate is enabled
// by defining SNAKE_READER_HIT_EN; without it, hit is tied low and query is
// ignored.

module snake_body_reader #(
    parameter int unsigned DEPTH = 250,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DEPTH*WIDTH-1:0] snake_in,
    input  logic [31:0]            length,
    input  logic                   start,
    input  logic [WIDTH-1:0]       query,
    output logic                   busy,
    output logic [WIDTH-1:0]       out_value,
    output logic [31:0]            out_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   done,
    output logic                   hit
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Index of the final beat (len-1); only meaningful when len > 0.
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] idx_next;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             beat_accepted;

    // Unpack the flat bank bus so entries can be selected by index.
    logic [WIDTH-1:0] entries [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : gen_unpack
        assign entries[g] = snake_in[WIDTH*g +: WIDTH];
    end

    assign idx_next      = idx_q + IDX_W'(1);
    assign beat_accepted = valid_q & out_ready;

`ifdef SNAKE_READER_HIT_EN
    logic [WIDTH-1:0] query_q, query_d;
    logic             hit_q, hit_d;

    // Query capture and sticky hit flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            query_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            query_q <= query_d;
            hit_q   <= hit_d;
        end
    end

    // Capture query and clear hit on an accepted start; accumulate matches
    // over accepted beats only, so stalled beats are counted once.
    always_comb begin
        query_d = query_q;
        hit_d   = hit_q;
        if (state_q == StIdle && start) begin
            query_d = query;
            hit_d   = 1'b0;
        end else if (state_q == StScan && beat_accepted) begin
            hit_d = hit_q | (value_q == query_q);
        end
    end

    assign hit = hit_q;
`else
    logic unused_query;

    assign unused_query = ^query;
    assign hit          = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= '0;
            idx_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: out_value only reloads when the index advances, so a
    // stalled beat stays stable even if the bank changes underneath it.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        value_d = value_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d = '0;
                    if (length >= 32'(DEPTH)) begin
                        last_d = LAST_MAX;
                    end else begin
                        last_d = length[IDX_W-1:0] - IDX_W'(1);
                    end
                    if (length == 32'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StScan;
                        valid_d = 1'b1;
                        value_d = entries[0];
                    end
                end
            end
            StScan: begin
                if (beat_accepted) begin
                    if (idx_q == last_q) begin
                        valid_d = 1'b0;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_next;
                        value_d = entries[idx_next];
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign out_value = value_q;
    assign out_index = 32'(idx_q);
    assign out_valid = valid_q;
    assign out_last  = valid_q & (idx_q == last_q);

endmodule

// File: tb/tb_snake_body_reader.sv
// Directed bench for snake_body_reader: reset, streaming, backpressure,
// length bounds, start-while-busy and back-to-back scans.

module tb_snake_body_reader;

    localparam int DEPTH = 250;
    localparam int WIDTH = 32;

`ifdef SNAKE_READER_HIT_EN
    localparam bit HitEn = 1'b1;
`else
    localparam bit HitEn = 1'b0;
`endif

    logic                   clock;
    logic                   reset;
    logic [DEPTH*WIDTH-1:0] snake_in;
    logic [31:0]            length;
    logic                   start;
    logic [WIDTH-1:0]       query;
    logic                   busy;
    logic [WIDTH-1:0]       out_value;
    logic [31:0]            out_index;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   done;
    logic                   hit;

    int vectors = 0;
    int errors  = 0;

    snake_body_reader #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .snake_in (snake_in),
        .length   (length),
        .start    (start),
        .query    (query),
        .busy     (busy),
        .out_value(out_value),
        .out_index(out_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .done     (done),
        .hit      (hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_entry(input int i, input logic [WIDTH-1:0] v);
        snake_in[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic load_small_bank();
        snake_in = '0;
        set_entry(0, 32'h10);
        set_entry(1, 32'h20);
        set_entry(2, 32'h30);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if ({busy, out_valid, out_last, done, hit} !== 5'b0 || out_index !== 32'd0 ||
            out_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_init: busy=%b valid=%b last=%b done=%b hit=%b idx=%0d val=%h, want all 0",
                     busy, out_valid, out_last, done, hit, out_index, out_value);
        end
        // Reset in the middle of a scan.
        load_small_bank();
        set_entry(3, 32'h40);
        set_entry(4, 32'h50);
        length = 32'd5;
        query  = 32'h10;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_index !== 32'd1) begin
            errors++;
            $display("FAIL reset_prescan: valid=%b idx=%0d, want 1/1", out_valid, out_index);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({busy, out_valid, done, hit} !== 4'b0 || out_index !== 32'd0) begin
            errors++;
            $display("FAIL reset_midscan: busy=%b valid=%b done=%b hit=%b idx=%0d, want 0",
                     busy, out_valid, done, hit, out_index);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if ({busy, out_valid, done} !== 3'b0) begin
                errors++;
                $display("FAIL reset_quiet%0d: busy=%b valid=%b done=%b, want 0",
                         k, busy, out_valid, done);
            end
        end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] exp_val [3];
        exp_val[0] = 32'h10;
        exp_val[1] = 32'h20;
        exp_val[2] = 32'h30;
        load_small_bank();
        out_ready = 1'b1;
        length    = 32'd3;
        query     = 32'h20;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if ({busy, out_valid, out_last} !== {2'b11, k == 2} ||
                out_index !== 32'(k) || out_value !== exp_val[k]) begin
                errors++;
                $display("FAIL stream_beat%0d: busy=%b valid=%b last=%b idx=%0d val=%h, want 1 1 %0b %0d %h",
                         k, busy, out_valid, out_last, out_index, out_value, k == 2, k, exp_val[k]);
            end
            tick();
        end
        vectors++;
        if ({busy, done, out_valid, hit} !== {3'b110, HitEn}) begin
            errors++;
            $display("FAIL stream_done: busy=%b done=%b valid=%b hit=%b, want 1 1 0 %b",
                     busy, done, out_valid, hit, HitEn);
        end
        tick();
        vectors++;
        if ({busy, done, hit} !== {2'b00, HitEn}) begin
            errors++;
            $display("FAIL stream_idle: busy=%b done=%b hit=%b, want 0 0 %b", busy, done, hit, HitEn);
        end
    endtask

    task automatic test_backpressure();
        load_small_bank();
        out_ready = 1'b1;
        length    = 32'd3;
        // 0xFF is only ever written into the bank during the stall, so it must never hit.
        query     = 32'hFF;
        start     = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (hit !== 1'b0 || out_index !== 32'd0 || out_value !== 32'h10) begin
            errors++;
            $display("FAIL bp_beat0: hit=%b idx=%0d val=%h, want 0 0 10", hit, out_index, out_value);
        end
        tick();
        out_ready = 1'b0;
        set_entry(1, 32'hFF);
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_index !== 32'd1 || out_value !== 32'h20 ||
                out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall%0d: valid=%b idx=%0d val=%h last=%b, want 1 1 20 0",
                         k, out_valid, out_index, out_value, out_last);
            end
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_index !== 32'd2 || out_value !== 32'h30 ||
            out_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_last: valid=%b idx=%0d val=%h last=%b, want 1 2 30 1",
                     out_valid, out_index, out_value, out_last);
        end
        tick();
        vectors++;
        if (done !== 1'b1 || out_valid !== 1'b0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: done=%b valid=%b hit=%b, want 1 0 0", done, out_valid, hit);
        end
        tick();
    endtask

    task automatic test_bounds();
        // Zero length: straight to DONE, no beats.
        length = 32'd0;
        query  = 32'h0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if ({busy, done, out_valid, hit} !== 4'b1100) begin
            errors++;
            $display("FAIL len0_done: busy=%b done=%b valid=%b hit=%b, want 1 1 0 0",
                     busy, done, out_valid, hit);
        end
        tick();
        vectors++;
        if ({busy, done, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL len0_idle: busy=%b done=%b valid=%b, want 0 0 0", busy, done, out_valid);
        end
        // Oversized length clamps to DEPTH; a start mid-scan must be ignored.
        for (int i = 0; i < DEPTH; i++) set_entry(i, 32'(i * 3 + 1));
        length    = 32'd300;
        query     = 32'(200 * 3 + 1);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            vectors++;
            if ({out_valid, out_last} !== {1'b1, k == DEPTH - 1} || out_index !== 32'(k) ||
                out_value !== 32'(k * 3 + 1)) begin
                errors++;
                $display("FAIL clamp_beat%0d: valid=%b last=%b idx=%0d val=%h, want 1 %0b %0d %h",
                         k, out_valid, out_last, out_index, out_value, k == DEPTH - 1, k,
                         32'(k * 3 + 1));
            end
            if (k == 100) begin
                length = 32'd2;
                query  = 32'h0;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        vectors++;
        if ({done, out_valid, hit} !== {2'b10, HitEn}) begin
            errors++;
            $display("FAIL clamp_done: done=%b valid=%b hit=%b, want 1 0 %b",
                     done, out_valid, hit, HitEn);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        load_small_bank();
        out_ready = 1'b1;
        length    = 32'd1;
        query     = 32'h77;
        start     = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || out_value !== 32'h10 || hit !== 1'b0) begin
            errors++;
            $display("FAIL b2b_beat: valid=%b last=%b val=%h hit=%b, want 1 1 10 0",
                     out_valid, out_last, out_value, hit);
        end
        tick();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: done=%b busy=%b, want 1 1", done, busy);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b valid=%b, want 0 0", busy, out_valid);
        end
        tick();
        start = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_index !== 32'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: valid=%b idx=%0d busy=%b, want 1 0 1",
                     out_valid, out_index, busy);
        end
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    initial begin
        reset     = 1'b1;
        snake_in  = '0;
        length    = 32'd0;
        start     = 1'b0;
        query     = '0;
        out_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_bounds();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
